// File: rtl/fifo_burst_reader.sv
// ============================================================================
// fifo_burst_reader : drains a fixed-length burst from a FWFT FIFO into a
//                     valid/ready stream through a 2-entry skid buffer.
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             start,
    input  logic [LSIZE-1:0] burst_len,
    input  logic             empty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic [DSIZE-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LSIZE-1:0] remaining_q, remaining_d;
    logic [DSIZE-1:0] head_q, head_d;
    logic             head_valid_q, head_valid_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             w_pop;
    logic             w_hs;

    // Space is judged on start-of-cycle occupancy, so a full skid blocks the
    // pop even when the head is being accepted this cycle.
    assign w_pop = (state_q == READ) && (remaining_q != '0) && !empty
                   && !(head_valid_q && skid_valid_q) && rrst_n;
    assign w_hs  = head_valid_q && dout_ready;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (w_hs) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = w_pop;
                if (w_pop) begin
                    skid_d = rdata;
                end
            end else begin
                head_valid_d = w_pop;
                if (w_pop) begin
                    head_d = rdata;
                end
            end
        end else if (w_pop) begin
            if (!head_valid_q) begin
                head_d       = rdata;
                head_valid_d = 1'b1;
            end else begin
                skid_d       = rdata;
                skid_valid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = burst_len;
                    state_d     = (burst_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (w_pop) begin
                    remaining_d = remaining_q - LSIZE'(1);
                    if (remaining_q == LSIZE'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!head_valid_d && !skid_valid_d) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == READ) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rinc       = w_pop;
    assign dout       = head_q;
    assign dout_valid = head_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// tb_fifo_burst_reader : randomized scoreboard bench with a FWFT FIFO model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

    localparam int DSIZE = 8;
    localparam int LSIZE = 8;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic             start = 1'b0;
    logic [LSIZE-1:0] burst_len = '0;
    logic             empty = 1'b1;
    logic [DSIZE-1:0] rdata = '0;
    logic             rinc;
    logic [DSIZE-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic             busy;
    logic             done;

    fifo_burst_reader #(.DSIZE(DSIZE), .LSIZE(LSIZE)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .start      (start),
        .burst_len  (burst_len),
        .empty      (empty),
        .rdata      (rdata),
        .rinc       (rinc),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // FIFO environment: word n written is value n (mod 2^DSIZE), n from 1
    logic [DSIZE-1:0] fifo[$];
    logic [DSIZE-1:0] exp_q[$];
    int  wr_count = 0, rd_count = 0, exp_idx = 0;
    int  add_req = 0, add_done = 0;
    int  feed_gap = 1, feed_left = 0, feed_ctr = 0;
    bit  feed_rand = 1'b0;
    bit  will_pop = 1'b0;
    int  ready_mode = 0;

    // Burst-level reference state
    int  cyc = 0;
    bit  active = 1'b0;
    int  start_cyc = 0, exp_done = -1, blen = 0, bpops = 0, bhs = 0;
    int  outst;
    bit  exp_rinc;
    logic [DSIZE-1:0] prev_dout = '0;
    bit  prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push_word();
        wr_count++;
        fifo.push_back(DSIZE'(wr_count));
    endfunction

    always @(posedge rclk) begin
        #1;
        if (will_pop) begin
            void'(fifo.pop_front());
            rd_count++;
        end
        while (add_done < add_req) begin
            push_word();
            add_done++;
        end
        if (feed_left > 0) begin
            feed_ctr++;
            if (feed_rand ? ($urandom_range(0, 2) == 0) : (feed_ctr >= feed_gap)) begin
                feed_ctr = 0;
                push_word();
                feed_left--;
            end
        end
        empty = (fifo.size() == 0);
        rdata = empty ? DSIZE'($urandom) : fifo[0];
    end

    always @(posedge rclk) begin
        #2;
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            2:       dout_ready = 1'($urandom_range(0, 1));
            default: dout_ready = 1'b0;
        endcase
    end

    always @(negedge rclk) begin
        cyc++;
        outst = bpops - bhs;
        if (!rrst_n) begin
            check("rinc_in_reset", {31'd0, rinc}, 32'd0);
            will_pop   = 1'b0;
            active     = 1'b0;
            exp_q.delete();
            exp_idx    = rd_count;
            exp_done   = -1;
            bpops      = 0;
            bhs        = 0;
            prev_stall = 1'b0;
        end else begin
            exp_rinc = active && (bpops < blen) && !empty && (outst < 2);
            check("rinc", {31'd0, rinc}, {31'd0, exp_rinc});
            check("dout_valid", {31'd0, dout_valid}, {31'd0, outst != 0});
            check("busy", {31'd0, busy}, {31'd0, active && (cyc != exp_done)});
            check("done", {31'd0, done}, {31'd0, active && (cyc == exp_done)});
            if (prev_stall) check("dout_stable", {24'd0, dout}, {24'd0, prev_dout});
            will_pop = rinc && !empty;
            if (will_pop) bpops++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dout cycle %0d: got %0d expected no word", cyc, dout);
                end else begin
                    check("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
                end
                bhs++;
                if (active && bhs == blen) exp_done = cyc + 1;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (active && cyc == exp_done) begin
                active = 1'b0;
            end else if (!active && start) begin
                active    = 1'b1;
                start_cyc = cyc;
                blen      = int'(burst_len);
                bpops     = 0;
                bhs       = 0;
                exp_done  = (blen == 0) ? cyc + 1 : -1;
                for (int k = 0; k < blen; k++) exp_q.push_back(DSIZE'(exp_idx + k + 1));
                exp_idx += blen;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rclk);
            #3;
        end
    endtask

    task automatic do_start(input int len);
        burst_len = LSIZE'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        burst_len = LSIZE'($urandom);
    endtask

    task automatic preload(input int n);
        add_req += n;
        tick(2);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((active || busy) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL timeout_%s: got busy after %0d cycles expected idle", nm, n);
        end
        tick(2);
    endtask

    initial begin
        tick(3);
        rrst_n = 1'b1;
        tick();
        check("dout_reset", {24'd0, dout}, 32'd0);

        // basic drain
        ready_mode = 0;
        preload(16);
        do_start(16);
        wait_idle("basic");

        // partial bursts
        preload(10);
        do_start(4);
        wait_idle("partial4");
        check("fifo_left_nonempty", {31'd0, empty}, 32'd0);
        do_start(6);
        wait_idle("partial6");

        // backpressure: held low, then alternate
        ready_mode = 3;
        preload(8);
        do_start(8);
        tick(6);
        check("pops_while_stalled", bpops, 2);
        ready_mode = 1;
        wait_idle("backpressure");

        // starved FIFO
        ready_mode = 0;
        feed_rand = 1'b0;
        feed_gap  = 3;
        feed_left = 5;
        do_start(5);
        wait_idle("starved");

        // zero-length burst, and start while busy
        do_start(0);
        wait_idle("zero");
        ready_mode = 1;
        preload(6);
        do_start(6);
        tick(2);
        do_start(3);
        wait_idle("start_busy");

        // reset after 3 pops
        ready_mode = 0;
        preload(8);
        do_start(8);
        for (int n = 0; n < 50 && bpops < 3; n++) tick();
        rrst_n = 1'b0;
        tick();
        rrst_n = 1'b1;
        tick();
        do_start(5);
        wait_idle("after_reset");
        check("fifo_drained", {31'd0, empty}, 32'd1);

        // randomized bursts
        ready_mode = 2;
        feed_rand  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int len;
            len = $urandom_range(1, 20);
            feed_left += len + $urandom_range(0, 2);
            do_start(len);
            wait_idle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side consumer for the asynchronous FIFO. It lives in the read clock domain. On a start pulse it drains exactly burst_len words from the FIFO read port (rinc/empty/rdata) and presents them on a valid/ready output stream through a 2-entry skid buffer. When the last word has been accepted downstream it pulses done. Throughput is one word per cycle while the FIFO is non-empty and the sink is ready.

Parameters:
DSIZE, 8, data width; must match the FIFO dsize.
LSIZE, 8, width of burst_len and of the remaining-word counter (max burst 2^LSIZE-1).

Ports:
rclk  input  1  read-domain clock, rising edge.
rrst_n  input  1  synchronous reset, active-low.
start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
burst_len  input  LSIZE  number of words to read; captured when start is accepted.
empty  input  1  FIFO empty flag (read domain).
rdata  input  DSIZE  FIFO head word; valid whenever empty=0 (first-word-fall-through).
rinc  output  1  FIFO pop; FIFO advances at the rclk edge where rinc=1 and empty=0.
dout  output  DSIZE  output stream data.
dout_valid  output  1  dout holds a valid word.
dout_ready  input  1  sink accepts dout on the edge where dout_valid=1 and dout_ready=1.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse: the burst has completed.

Behaviour:
- States: IDLE, READ, FLUSH, DONE. All registers update on the rclk rising edge.
- Reset (rrst_n=0 at an edge): state=IDLE, remaining=0, skid occupancy=0, dout=0, dout_valid=0, busy=0, done=0.
- Reset during the rrst_n=0 cycle: rinc is forced to 0 combinationally. Any buffered words are discarded. Reset mid-burst leaves the FIFO pointer at however many words were already popped.
- IDLE: when start=1, capture remaining<=burst_len.
  - burst_len=0: go to DONE.
  - otherwise: go to READ; busy=1 from the next cycle.
- start while not IDLE: ignored.
- READ: rinc = (remaining!=0) && !empty && (occ<2). occ is the skid occupancy registered at the start of the cycle, before this cycle's output handshake.
  - On each pop: remaining decrements by 1, and rdata is written into the skid.
  - When remaining reaches 0 after a pop: go to FLUSH.
- Skid buffer: 2 entries, FIFO order.
  - dout/dout_valid come from the head entry register.
  - A popped word appears on dout at the cycle after the pop edge (latency 1) if the head is free or is being consumed; otherwise it is held in the second entry.
  - Simultaneous pop and output handshake: occupancy unchanged, order preserved.
  - dout is stable while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a handshake.
- FLUSH: rinc=0. When occupancy reaches 0 (last handshake completed): go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Outside READ, rinc=0. rinc is never 1 while empty=1.
- empty toggling mid-burst only stalls pops; no words are lost or duplicated.
- dout_ready=0 for many cycles: at most 2 words are popped, then rinc=0 until space frees.
- remaining arithmetic is unsigned, LSIZE bits, never underflows.

Test Plan:
- Basic drain: FIFO preloaded with 1..16, start with burst_len=16, dout_ready=1. Required response:
  - rinc high for 16 consecutive cycles.
  - dout sequence 1..16, one word per cycle, first word one cycle after the first rinc.
  - done pulses one cycle after word 16 is accepted; busy then falls.
- Partial burst: FIFO holds 1..10, burst_len=4. Required: dout 1,2,3,4 then done; FIFO left holding 5..10 (empty=0); a second start with burst_len=6 yields 5..10.
- Backpressure: burst_len=8, dout_ready low on alternate cycles. Required:
  - dout=1..8 in order, no duplicates.
  - dout stable while stalled.
  - occupancy never exceeds 2.
  - with dout_ready held low for 5 cycles, exactly 2 pops occur, then rinc=0.
- Starved FIFO: burst_len=5, FIFO initially empty, words written one every 3 read cycles. Required:
  - rinc only in cycles with empty=0.
  - dout=1..5.
  - done after the 5th handshake.
- Edge cases: burst_len=0 gives done one cycle after start with rinc never asserted. start while busy is ignored, and remaining is unaffected.
- Reset mid-burst: rrst_n low for 1 cycle after 3 of 8 pops. Required:
  - rinc=0 in the reset cycle.
  - next cycle: dout_valid=0, busy=0, done=0, state IDLE.
  - a new start with burst_len=5 returns FIFO words 4..8.
